// File: rtl/mux4_tree_pkg.sv
// Shared constants for the mux4_tree block: default data width and select encodings.
package mux4_tree_pkg;

    localparam int unsigned MUX4_WIDTH_DEFAULT = 1;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_tree_mux2.sv
// Generic WIDTH-bit 2:1 multiplexer; the leaf cell of the mux4_tree.
module mux2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux4_tree.sv
// Four-input mux as a two-level tree of mux2 cells, with a combinational
// result f and an async-reset registered copy f_q.
module mux4_tree
    import mux4_tree_pkg::*;
#(
    parameter int unsigned WIDTH = MUX4_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] f_q
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;

    // First level: s0 picks within each pair.
    mux2 #(.WIDTH(WIDTH)) u_mux_lo (.a(i0), .b(i1), .s(s0), .y(lo));
    mux2 #(.WIDTH(WIDTH)) u_mux_hi (.a(i2), .b(i3), .s(s0), .y(hi));

    // Second level: s1 picks between the pairs.
    mux2 #(.WIDTH(WIDTH)) u_mux_out (.a(lo), .b(hi), .s(s1), .y(f));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= '0;
        end else begin
            f_q <= f;
        end
    end

endmodule

// File: tb/tb_mux4_tree.sv
// Self-checking bench for mux4_tree: directed sweeps, reset behaviour and a
// randomized run against an array-indexed reference model.
module tb_mux4_tree;

    logic       clk;
    logic       rst;
    logic       s1;
    logic       s0;
    logic [7:0] i0, i1, i2, i3;
    logic [7:0] f, f_q;
    logic       b0, b1, b2, b3;
    logic       g, g_q;

    int errors;
    int checks;

    mux4_tree #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .s1(s1), .s0(s0),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .f(f), .f_q(f_q)
    );

    mux4_tree #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .s1(s1), .s0(s0),
        .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .f(g), .f_q(g_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick element number {s1,s0} from the four inputs.
    function automatic logic [7:0] ref_mux(input logic [1:0] sel, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c,
                                           input logic [7:0] d);
        logic [7:0] t [4];
        t[0] = a;
        t[1] = b;
        t[2] = c;
        t[3] = d;
        return t[sel];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        {s1, s0} = 2'b11;
        i0 = 8'h00; i1 = 8'h00; i2 = 8'h00; i3 = 8'h5A;
        b0 = 1'b0; b1 = 1'b0; b2 = 1'b0; b3 = 1'b1;
        #2;
        checks++;
        if (f_q !== 8'h00) begin
            errors++;
            $display("FAIL reset_fq8: got %h expected 00", f_q);
        end
        checks++;
        if (g_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_fq1: got %b expected 0", g_q);
        end
        checks++;
        if (f !== 8'h5A) begin
            errors++;
            $display("FAIL reset_f_live: got %h expected 5a", f);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_sweep();
        logic [0:0] expv [4];
        expv[0] = 1'b0; expv[1] = 1'b0; expv[2] = 1'b1; expv[3] = 1'b1;
        b0 = 1'b0; b1 = 1'b0; b2 = 1'b1; b3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            #5;
            checks++;
            if (g !== expv[k]) begin
                errors++;
                $display("FAIL truth_sweep sel=%0d: got %b expected %b", k, g, expv[k]);
            end
        end
    endtask

    task automatic test_distinct();
        logic [7:0] expv [4];
        expv[0] = 8'h11; expv[1] = 8'h22; expv[2] = 8'h44; expv[3] = 8'h88;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i0 = 8'h11; i1 = 8'h22; i2 = 8'h44; i3 = 8'h88;
            {s1, s0} = 2'(k);
            #1;
            checks++;
            if (f !== expv[k]) begin
                errors++;
                $display("FAIL distinct_f sel=%0d: got %h expected %h", k, f, expv[k]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (f_q !== expv[k]) begin
                errors++;
                $display("FAIL distinct_fq sel=%0d: got %h expected %h", k, f_q, expv[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        i0 = 8'hFF; i1 = 8'hFF; i2 = 8'hFF; i3 = 8'hFF;
        {s1, s0} = 2'b00;
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 8'hFF) begin
            errors++;
            $display("FAIL arst_load: got %h expected ff", f_q);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (f_q !== 8'h00) begin
            errors++;
            $display("FAIL arst_immediate: got %h expected 00", f_q);
        end
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (f_q !== 8'h00) begin
                errors++;
                $display("FAIL arst_hold edge=%0d: got %h expected 00", n, f_q);
            end
            checks++;
            if (f !== 8'hFF) begin
                errors++;
                $display("FAIL arst_f_unaffected edge=%0d: got %h expected ff", n, f);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        i1 = 8'hA5;
        {s1, s0} = 2'b01;
        #1;
        checks++;
        if (f_q !== 8'h00) begin
            errors++;
            $display("FAIL arst_release_noedge: got %h expected 00", f_q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (f_q !== 8'hA5) begin
            errors++;
            $display("FAIL arst_release_load: got %h expected a5", f_q);
        end
    endtask

    task automatic test_isolation();
        logic [7:0] held;
        @(negedge clk);
        i0 = 8'h01; i1 = 8'h02; i2 = 8'h3C; i3 = 8'h08;
        {s1, s0} = 2'b10;
        #1;
        held = 8'h3C;
        for (int n = 0; n < 3; n++) begin
            case (n)
                0: i0 = ~i0;
                1: i1 = ~i1;
                default: i3 = ~i3;
            endcase
            #0;
            #1;
            checks++;
            if (f !== held) begin
                errors++;
                $display("FAIL isolation toggle=%0d: got %h expected %h", n, f, held);
            end
        end
        i2 = 8'hC3;
        #1;
        checks++;
        if (f !== 8'hC3) begin
            errors++;
            $display("FAIL isolation_i2: got %h expected c3", f);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_f;
        logic [7:0] exp_q;
        logic [1:0] sel;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            i0 = 8'($urandom); i1 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
            b0 = 1'($urandom); b1 = 1'($urandom); b2 = 1'($urandom); b3 = 1'($urandom);
            sel = 2'($urandom_range(3, 0));
            {s1, s0} = sel;
            #1;
            exp_f = ref_mux(sel, i0, i1, i2, i3);
            checks++;
            if (f !== exp_f) begin
                errors++;
                $display("FAIL random_f cyc=%0d sel=%0d: got %h expected %h", n, sel, f, exp_f);
            end
            checks++;
            if (g !== ref_mux(sel, 8'(b0), 8'(b1), 8'(b2), 8'(b3)) ) begin
                errors++;
                $display("FAIL random_f1 cyc=%0d sel=%0d: got %b", n, sel, g);
            end
            exp_q = exp_f;
            @(posedge clk);
            #1;
            checks++;
            if (f_q !== exp_q) begin
                errors++;
                $display("FAIL random_fq cyc=%0d: got %h expected %h", n, f_q, exp_q);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_truth_sweep();
        test_distinct();
        test_async_reset();
        test_isolation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_tree.md
# mux4_tree

Four-input multiplexer built as a two-level tree of 2:1 multiplexers. It has a combinational output and a registered copy of the same value. It is a leaf datapath block: upstream logic drives the four data inputs and a 2-bit select, and downstream logic takes either the same-cycle result `f` or the clocked result `f_q`.

## Interface

One clock; reset is asynchronous and active-high.

**Parameters**
- `WIDTH`, default 1: bit width of each data input and of both outputs.

**Ports**
- `clk`  in  1  clock; rising-edge active, used only by the output register
- `rst`  in  1  asynchronous, active-high reset of the output register
- `s1`  in  1  select MSB; chooses between the two first-level results
- `s0`  in  1  select LSB; drives both first-level 2:1 muxes
- `i0`  in  WIDTH  data, selected when {s1,s0}=00
- `i1`  in  WIDTH  data, selected when {s1,s0}=01
- `i2`  in  WIDTH  data, selected when {s1,s0}=10
- `i3`  in  WIDTH  data, selected when {s1,s0}=11
- `f`  out  WIDTH  combinational mux result
- `f_q`  out  WIDTH  `f` registered on `clk`

## Operation

- First level, two `mux2` instances, both selected by `s0`:
  - lo = s0 ? i1 : i0
  - hi = s0 ? i3 : i2
- Second level, one `mux2` selected by `s1`: f = s1 ? hi : lo.
- Net function: f = i[{s1,s0}], applied bitwise across WIDTH.
- Any X/Z on a select may propagate X to `f`. No X-masking logic is required.
- `f_q` is loaded with `f` on every rising `clk` edge. There is no enable.
- No state exists other than `f_q`. There is no handshake and no FSM.

## Timing

- `f`: zero-cycle latency, purely combinational from all data and select inputs. It is never affected by `rst`.
- `f_q`: one-cycle latency. The value of `f` sampled at edge N appears on `f_q` after edge N.
- Reset value of `f_q` is all zeros.
- `rst` asserted: `f_q` clears immediately, with no clock edge required. It holds 0 for as long as `rst` is high.
- `rst` deasserted: the first rising edge with `rst` low loads `f`.
- Reset mid-operation overrides any in-flight capture.
- Changes to select and data within a cycle: only the value at the rising edge is captured. Glitches on `f` between edges are permitted.

## Structure

- Sub-module `mux2`:
  - parameter WIDTH
  - ports a, b, s, y, with y = s ? b : a
  - instantiated three times
- The top level contains the three `mux2` instances plus one always_ff with async reset for `f_q`.
- Shared package `mux4_tree_pkg` holds:
  - the default width constant `MUX4_WIDTH_DEFAULT = 1`
  - the select encoding constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I3=2'b11

## Test plan

- Combinational truth sweep, WIDTH=1, i0=0, i1=0, i2=1, i3=1. Step {s1,s0} through 00, 01, 10, 11 at 5-time-unit intervals. Required f: 0, 0, 1, 1.
- Distinct-value sweep, WIDTH=8, i0=8'h11, i1=8'h22, i2=8'h44, i3=8'h88. For {s1,s0} = 00, 01, 10, 11 the required f is 11, 22, 44, 88. Each value appears on `f_q` one clock later.
- Reset:
  - Load f=8'hFF into `f_q`.
  - Assert `rst` between clock edges: `f_q` goes to 00 immediately, without an edge.
  - While `rst` is held, edges keep `f_q` at 00.
  - After release, the next edge loads the current `f`.
- Data-change isolation: with select fixed at 10, toggling i0, i1 and i3 leaves `f` unchanged. Toggling i2 changes `f` in the same delta.
- Randomized check, 1000 cycles with random data and select: `f` matches the reference i[{s1,s0}] every cycle, and `f_q` equals the previous cycle's `f`.
